// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack handshake,
// holds them in IR and computes the next PC on each update request.
module instr_fetch_unit #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          upd_pc,
  input  logic [2:0]    br_op,
  input  logic          flag_n,
  input  logic          flag_z,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_ack,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  output logic [AW-1:0] pc,
  output logic [31:0]   ir,
  output logic          ir_valid,
  output logic [5:0]    opcode,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [4:0]    func,
  output logic [31:0]   imm,
  output logic          fetch_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  logic [1:0]           state;
  logic [CW-1:0]        tcnt;
  logic                 upd_q;
  logic                 upd_rise;
  logic                 taken;
  logic signed [AW-1:0] br_off;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign func   = ir[4:0];
  assign imm    = {{16{ir[15]}}, ir[15:0]};

  // Word-aligned branch offset: sign-extended immediate scaled by 4.
  assign br_off = {{(AW-18){ir[15]}}, ir[15:0], 2'b00};

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign upd_rise  = upd_pc & ~upd_q;

  always_comb begin
    taken = 1'b0;
    case (br_op)
      3'b000:  taken = 1'b1;
      3'b001:  taken = flag_n;
      3'b010:  taken = ~flag_n & ~flag_z;
      3'b011:  taken = flag_z;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
      tcnt      <= '0;
      upd_q     <= 1'b0;
    end else begin
      upd_q     <= upd_pc;
      fetch_err <= 1'b0;
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            tcnt     <= '0;
            state    <= HOLD;
          end else if (tcnt == TLAST) begin
            // Retry at the same address; the request never drops.
            fetch_err <= 1'b1;
            tcnt      <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        HOLD: begin
          if (upd_rise) begin
            pc       <= taken ? pc + br_off : pc + AW'(4);
            ir_valid <= 1'b0;
            state    <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed branch/timeout/reset
// scenarios plus randomized fetch sequences against a PC/decode model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        upd_pc;
  logic [2:0]  br_op;
  logic        flag_n;
  logic        flag_z;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        ir_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  func;
  logic [31:0] imm;
  logic        fetch_err;

  int checks;
  int failures;

  logic [31:0] exp_pc;
  logic [31:0] last_word;

  instr_fetch_unit #(.AW(32), .RESET_PC(32'h0), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .upd_pc(upd_pc), .br_op(br_op),
    .flag_n(flag_n), .flag_z(flag_z), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .imem_req(imem_req), .imem_addr(imem_addr),
    .pc(pc), .ir(ir), .ir_valid(ir_valid), .opcode(opcode), .rs(rs),
    .rt(rt), .rd(rd), .func(func), .imm(imm), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Branch decision from the brOp table.
  function automatic bit model_taken(input logic [2:0] op, input logic n, input logic z);
    if (op[2]) return 1'b0;
    if (op == 3'd0) return 1'b1;
    if (op == 3'd1) return n;
    if (op == 3'd2) return !n && !z;
    return z;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic [2:0] op, input logic n, input logic z);
    longint off;
    longint sum;
    off = longint'(word[15:0]);
    if (off >= 32768) off = off - 65536;
    if (model_taken(op, n, z)) sum = longint'(cur) + off * 4;
    else sum = longint'(cur) + 4;
    return 32'(sum & 64'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] word);
    return word[15] ? (32'hFFFF_0000 | {16'h0, word[15:0]}) : {16'h0, word[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one update request edge with the given branch conditions.
  task automatic do_update(input logic [2:0] op, input logic n, input logic z);
    br_op = op; flag_n = n; flag_z = z; upd_pc = 1'b1;
    tick();
    upd_pc = 1'b0;
    br_op = 3'($urandom); flag_n = 1'($urandom); flag_z = 1'($urandom);
  endtask

  // Memory responder: ack after lat idle REQ cycles.
  task automatic serve(input logic [31:0] w, input int lat);
    int n;
    n = 0;
    while (!imem_req && n < 50) begin tick(); n++; end
    checks++;
    if (imem_req !== 1'b1) begin
      failures++;
      $display("FAIL serve_wait: imem_req=%b required 1", imem_req);
    end
    repeat (lat) tick();
    imem_ack = 1'b1; imem_rdata = w;
    tick();
    imem_ack = 1'b0; imem_rdata = $urandom;
    last_word = w;
  endtask

  task automatic test_reset();
    rst = 1'b0; upd_pc = 1'b0; br_op = 3'b0; flag_n = 1'b0; flag_z = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (3) tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 0", pc); end
    checks++; if (ir !== 32'h0) begin failures++; $display("FAIL reset_ir: got %h want 0", ir); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL reset_irv: got %b want 0", ir_valid); end
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", fetch_err); end
  endtask

  task automatic test_first_fetch();
    rst = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL first_req: req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
    serve(32'h0422_0005, 2);
    exp_pc = 32'h0;
    checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL first_irv: got %b want 1", ir_valid); end
    checks++; if (opcode !== 6'b000001 || rs !== 5'd1 || rt !== 5'd2) begin
      failures++; $display("FAIL first_fields: op=%b rs=%0d rt=%0d want 000001/1/2", opcode, rs, rt);
    end
    checks++; if (imm !== 32'd5 || pc !== 32'h0) begin
      failures++; $display("FAIL first_imm_pc: imm=%h pc=%h want 5/0", imm, pc);
    end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL first_req_drop: got %b want 0", imem_req); end
  endtask

  task automatic test_no_retrigger();
    br_op = 3'b100; upd_pc = 1'b1;
    tick();
    checks++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      failures++; $display("FAIL seq_fetch: irv=%b req=%b addr=%h want 0/1/4", ir_valid, imem_req, imem_addr);
    end
    // imm = 7 so an always-branch from pc 4 lands on 0x20
    serve(32'h8C43_0007, 1);
    repeat (5) tick();
    checks++; if (imem_req !== 1'b0 || ir_valid !== 1'b1 || pc !== 32'h4) begin
      failures++; $display("FAIL no_retrigger: req=%b irv=%b pc=%h want 0/1/4", imem_req, ir_valid, pc);
    end
    upd_pc = 1'b0;
    tick();
  endtask

  task automatic test_branches();
    do_update(3'b000, 1'b0, 1'b0);
    checks++; if (pc !== 32'h20) begin failures++; $display("FAIL br_always: pc=%h want 20", pc); end
    serve(32'h1000_FFFE, 0);
    do_update(3'b011, 1'b0, 1'b1);
    checks++; if (pc !== 32'h18) begin failures++; $display("FAIL br_z_taken: pc=%h want 18", pc); end
    serve(32'h0000_0002, 3);
    do_update(3'b000, 1'b1, 1'b1);
    checks++; if (pc !== 32'h20) begin failures++; $display("FAIL br_back: pc=%h want 20", pc); end
    serve(32'h1000_FFFE, 1);
    do_update(3'b011, 1'b1, 1'b0);
    checks++; if (pc !== 32'h24) begin failures++; $display("FAIL br_z_not: pc=%h want 24", pc); end
    serve(32'h0000_0010, 0);
    do_update(3'b010, 1'b0, 1'b1);
    checks++; if (pc !== 32'h28) begin failures++; $display("FAIL br_pos_not: pc=%h want 28", pc); end
    serve(32'h0000_0010, 2);
    do_update(3'b001, 1'b1, 1'b0);
    checks++; if (pc !== 32'h68) begin failures++; $display("FAIL br_n_taken: pc=%h want 68", pc); end
    serve(32'h0000_FFE5, 0);
    do_update(3'b000, 1'b0, 1'b0);
    checks++; if (pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL br_wrap_neg: pc=%h want fffffffc", pc); end
    serve(32'h0000_7FFF, 1);
    do_update(3'b111, 1'b1, 1'b1);
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL seq_wrap: pc=%h want 0", pc); end
    serve(32'h0000_0001, 0);
    exp_pc = 32'h0;
  endtask

  task automatic test_timeout();
    int pulses;
    int pulse_at;
    bit addr_bad;
    do_update(3'b100, 1'b0, 1'b0);
    pulses = 0; pulse_at = 0; addr_bad = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 3) upd_pc = 1'b1;
      if (i == 5) upd_pc = 1'b0;
      tick();
      if (fetch_err === 1'b1) begin pulses++; pulse_at = i; end
      if (imem_req !== 1'b1 || imem_addr !== 32'h4) addr_bad = 1'b1;
    end
    checks++; if (pulses != 1 || pulse_at != 15) begin
      failures++; $display("FAIL timeout_pulse: pulses=%0d at=%0d want 1 at 15", pulses, pulse_at);
    end
    checks++; if (addr_bad) begin failures++; $display("FAIL timeout_hold: request dropped or address moved, want req=1 addr=4"); end
    imem_ack = 1'b1; imem_rdata = 32'hABCD_1234;
    tick();
    imem_ack = 1'b0;
    last_word = 32'hABCD_1234;
    exp_pc = 32'h4;
    checks++; if (ir !== 32'hABCD_1234 || ir_valid !== 1'b1 || pc !== 32'h4) begin
      failures++; $display("FAIL timeout_load: ir=%h irv=%b pc=%h want abcd1234/1/4", ir, ir_valid, pc);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic        n, z;
    logic [31:0] w;
    logic [31:0] nxt;
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom); n = 1'($urandom); z = 1'($urandom);
      w = $urandom;
      nxt = model_next(exp_pc, last_word, op, n, z);
      do_update(op, n, z);
      exp_pc = nxt;
      checks++; if (pc !== exp_pc || imem_addr !== exp_pc || ir_valid !== 1'b0) begin
        failures++; $display("FAIL rand_pc[%0d]: pc=%h addr=%h irv=%b want %h/%h/0", k, pc, imem_addr, ir_valid, exp_pc, exp_pc);
      end
      serve(w, int'($urandom_range(0, 4)));
      checks++; if (ir !== w || ir_valid !== 1'b1 || pc !== exp_pc) begin
        failures++; $display("FAIL rand_ir[%0d]: ir=%h irv=%b pc=%h want %h/1/%h", k, ir, ir_valid, pc, w, exp_pc);
      end
      checks++; if (opcode !== 6'(w >> 26) || rs !== 5'(w >> 21) || rt !== 5'(w >> 16) ||
                    rd !== 5'(w >> 11) || func !== 5'(w) || imm !== model_imm(w)) begin
        failures++; $display("FAIL rand_dec[%0d]: op=%h rs=%h rt=%h rd=%h fn=%h imm=%h for word %h", k, opcode, rs, rt, rd, func, imm, w);
      end
      repeat (int'($urandom_range(0, 2))) tick();
    end
  endtask

  task automatic test_reset_mid_req();
    do_update(3'b100, 1'b0, 1'b0);
    tick();
    #2 rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || pc !== 32'h0 || ir_valid !== 1'b0 || ir !== 32'h0) begin
      failures++; $display("FAIL async_reset: req=%b pc=%h irv=%b ir=%h want 0/0/0/0", imem_req, pc, ir_valid, ir);
    end
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; rst = 1'b1;
    tick();
    imem_ack = 1'b0;
    checks++; if (ir_valid !== 1'b0 || ir !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL idle_ack: irv=%b ir=%h req=%b addr=%h want 0/0/1/0", ir_valid, ir, imem_req, imem_addr);
    end
    serve(32'h2108_0003, 1);
    checks++; if (ir !== 32'h2108_0003 || ir_valid !== 1'b1 || pc !== 32'h0) begin
      failures++; $display("FAIL post_reset_load: ir=%h irv=%b pc=%h want 21080003/1/0", ir, ir_valid, pc);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    exp_pc = 32'h0; last_word = 32'h0;
    test_reset();
    test_first_fetch();
    test_no_retrigger();
    test_branches();
    test_timeout();
    test_random();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the multicycle control unit.
- Holds the PC and fetches 32-bit instructions from instruction memory using a req/ack handshake.
- Latches each fetched word into an instruction register and presents the decoded opcode/func/register/immediate fields to the control unit and datapath.
- On each update-PC request from the control unit, computes the next PC (sequential or branch target per brOp and ALU flags) and starts the next fetch.

Parameters:
- AW, 32: PC / instruction-memory address width.
- RESET_PC, 0: first fetch address after reset.
- TIMEOUT, 15: maximum cycles to wait for imem_ack before flagging an error and reissuing the request.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- upd_pc  in  1  updPC level from the control unit; a 0->1 transition requests the next instruction.
- br_op  in  3  branch op, sampled on the upd_pc rising edge: 000 always, 001 if flag_n, 010 if !flag_n && !flag_z, 011 if flag_z, 1xx never.
- flag_n  in  1  ALU negative flag.
- flag_z  in  1  ALU zero flag.
- imem_rdata  in  32  instruction word; valid in the cycle imem_ack=1.
- imem_ack  in  1  memory response strobe.
- imem_req  out  1  read request; held high until ack.
- imem_addr  out  AW  read address; equals pc while imem_req=1.
- pc  out  AW  address of the instruction currently in IR.
- ir  out  32  instruction register.
- ir_valid  out  1  IR holds a fetched instruction not yet retired.
- opcode  out  6  ir[31:26].
- rs  out  5  ir[25:21].
- rt  out  5  ir[20:16].
- rd  out  5  ir[15:11].
- func  out  5  ir[4:0].
- imm  out  32  sign-extended ir[15:0].
- fetch_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; pc=RESET_PC.
  - ir=0, ir_valid=0, imem_req=0, fetch_err=0, timeout counter=0, upd_pc edge register=0.
  - An outstanding request is abandoned. Any ack arriving while not in REQ is ignored.
- Decoded outputs (opcode, rs, rt, rd, func, imm) are combinational from ir.
- States: IDLE, REQ, HOLD.
- IDLE: the first clock after reset release goes to REQ.
- REQ:
  - imem_req=1 and imem_addr=pc.
  - On imem_ack=1: ir<=imem_rdata, ir_valid<=1, imem_req<=0, go to HOLD. Minimum latency from entering REQ to ir_valid is 1 cycle; an ack in the first REQ cycle is legal.
  - The counter increments each cycle without ack. When it reaches TIMEOUT: fetch_err pulses, counter clears, stay in REQ with imem_req held high (retry at the same address).
- HOLD:
  - IR is stable.
  - An upd_pc rising edge is detected as upd_pc=1 with the previous sample 0.
  - On that edge, branch is taken iff the br_op condition holds using flag_n and flag_z sampled in the same cycle.
  - Next pc = taken ? pc + (imm << 2) : pc + 4. Use AW-bit modulo arithmetic; wrap-around at 2^AW is silent.
  - In the same cycle: ir_valid<=0 and go to REQ.
- A level-high upd_pc does not re-trigger. Edges seen in IDLE or REQ are ignored; the edge register still tracks upd_pc, so no edge is queued.
- br_op and the flags are don't-care except on the HOLD edge cycle.
- Reset asserted mid-REQ or mid-HOLD gives the IDLE values immediately, with no clock required.

Test Plan:
- Release reset, memory acks after 2 cycles with 0x0422_0005 -> imem_addr=0; ir_valid rises; opcode=000001, rs=1, rt=2, imm=5, pc=0.
- In HOLD, upd_pc 0->1 with br_op=100 -> next imem_addr=4; ir_valid drops the same cycle; holding upd_pc high causes no second fetch.
- pc=0x20, imm=0xFFFE, br_op=011, flag_z=1 -> next pc=0x18. Repeat with flag_z=0 -> next pc=0x24.
- br_op=010 with flag_n=0, flag_z=1 -> not taken (pc+4). br_op=001 with flag_n=1 -> taken.
- No ack for 15 cycles -> fetch_err pulses once, imem_req stays 1 at the same address; ack on cycle 17 -> IR loads normally.
- Drop rst mid-REQ -> imem_req=0, pc=RESET_PC asynchronously; a late ack after release while in IDLE does not load IR.
